servant_irq_ctrl: RTL

//  Interrupt aggregator between the interrupt producers (timer o_irq, GPIO, UART) and the SERV

---
 rtl/servant_irq_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/servant_irq_ctrl.sv
// servant_irq_ctrl
//   Interrupt aggregator for the SERV core. Each raw source is synchronised
//   into i_clk. Depending on EDGE_MASK it is either latched on its rising
//   edge into PENDING (cleared by writing 1) or tracked as a level. PENDING
//   is masked by ENABLE, and the OR of the result drives a registered o_irq.
//   The block is a 4-word Wishbone slave: 0 PENDING, 1 ENABLE, 2 STATUS,
//   3 RAW.
//
// Ports
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_src     raw interrupt sources, active-high, N_SRC bits
//   i_wb_adr  word address (byte address bits [3:2])
//   i_wb_dat  write data
//   i_wb_we   write enable
//   i_wb_cyc  combined cycle/strobe
//   o_wb_ack  one-cycle acknowledge
//   o_wb_dat  read data, valid while o_wb_ack=1 (holds otherwise)
//   o_irq     registered interrupt request to the core
module servant_irq_ctrl #(
  parameter int          N_SRC       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_MASK   = 32'h0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_src,
  input  logic [1:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_dat,
  output logic             o_irq
);

  logic             ack_reg;
  logic [31:0]      dat_reg;
  logic             irq_reg;
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] sp_reg;
  logic [N_SRC-1:0] pend_reg;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] en_reg;
  logic [N_SRC-1:0] w1c;
  logic [31:0]      rdata;
  logic             wr;
  logic             rd_strobe;

  // One access per transaction: the cycle in which ack is low is the one
  // that both writes and samples the read mux.
  assign rd_strobe = i_wb_cyc & ~ack_reg;
  assign wr        = rd_strobe & i_wb_we;
  assign w1c       = (wr && i_wb_adr == 2'd0) ? i_wb_dat[N_SRC-1:0] : '0;

  // Source synchroniser; s is the synchronised level.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = i_src;
    end else begin : g_sync
      logic [N_SRC-1:0] sync_reg [SYNC_STAGES];
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
        end else begin
          sync_reg[0] <= i_src;
          for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
        end
      end
      assign s = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  // Per-source pending logic. For edge sources a new edge beats a
  // simultaneous software clear so no interrupt is ever dropped.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      if (EDGE_MASK[gi]) begin : g_edge
        assign pend_next[gi] = (s[gi] & ~sp_reg[gi]) ? 1'b1 :
                               w1c[gi]               ? 1'b0 : pend_reg[gi];
      end else begin : g_level
        assign pend_next[gi] = s[gi];
      end
    end
  endgenerate

  always_comb begin
    rdata = '0;
    case (i_wb_adr)
      2'd0:    rdata[N_SRC-1:0] = pend_reg;
      2'd1:    rdata[N_SRC-1:0] = en_reg;
      2'd2:    rdata[N_SRC-1:0] = pend_reg & en_reg;
      default: rdata[N_SRC-1:0] = s;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_reg  <= 1'b0;
      dat_reg  <= '0;
      irq_reg  <= 1'b0;
      sp_reg   <= '0;
      pend_reg <= '0;
      en_reg   <= '0;
    end else begin
      ack_reg  <= rd_strobe;
      if (rd_strobe) dat_reg <= rdata;   // reads see pre-update state
      sp_reg   <= s;
      pend_reg <= pend_next;
      if (wr && i_wb_adr == 2'd1) en_reg <= i_wb_dat[N_SRC-1:0];
      irq_reg  <= |(pend_reg & en_reg);
    end
  end

  assign o_wb_ack = ack_reg;
  assign o_wb_dat = dat_reg;
  assign o_irq    = irq_reg;

endmodule
